// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD widths, demux FSM encodings and the clogb2 sizing helper
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;
   function automatic int clogb2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/bcd_stable_detect.sv
// bcd_stable_detect: registers the select/data pair and flags it once unchanged for SETTLE_CYCLES
module bcd_stable_detect import bcd_pkg::*; #(
   parameter int DISPLAYS_NUM  = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [DISPLAYS_NUM-1:0] bcd_sel,
   input  logic [BCD_W-1:0]        bcd_muxed,
   output logic [DISPLAYS_NUM-1:0] sel,
   output logic [BCD_W-1:0]        dat,
   output logic                    settled,
   output logic                    changed
);
   localparam int CW = clogb2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] S_MAX  = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
   logic [DISPLAYS_NUM+BCD_W-1:0] prev;
   logic [CW-1:0] cnt;
   assign changed = {sel, dat} != prev;
   assign settled = !changed && cnt == S_LAST;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sel  <= '0;
         dat  <= '0;
         prev <= '0;
         cnt  <= '0;
      end else begin
         sel  <= bcd_sel;
         dat  <= bcd_muxed;
         prev <= {sel, dat};
         cnt  <= changed ? '0 : (cnt == S_MAX ? cnt : cnt + CW'(1));
      end
   end
endmodule

// File: rtl/bcd_demux.sv
// bcd_demux: rebuilds the parallel BCD word from a scanned digit bus, one valid pulse per full frame
// Optional BCD_DEMUX_BCD_CHECK_EN rejects nibbles above 9 and discards the frame in progress
module bcd_demux import bcd_pkg::*; #(
   parameter int DISPLAYS_NUM  = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [BCD_W-1:0]              i_bcd_muxed,
   input  logic [DISPLAYS_NUM-1:0]       i_bcd_sel,
   output logic [DISPLAYS_NUM*BCD_W-1:0] o_bcd_data,
   output logic                          o_frame_valid,
   output logic [DISPLAYS_NUM-1:0]       o_digit_mask,
   output logic                          o_sel_err,
   output logic                          o_bcd_err
);
   logic [DISPLAYS_NUM-1:0] r_sel, mask, mask_base;
   logic [BCD_W-1:0] r_dat;
   logic [DISPLAYS_NUM*BCD_W-1:0] shadow;
   logic settled, changed, one_hot, full, bad, cap, wr;
   state_t state;
   bcd_stable_detect #(.DISPLAYS_NUM(DISPLAYS_NUM), .SETTLE_CYCLES(SETTLE_CYCLES)) u_stable (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bcd_sel(i_bcd_sel),
      .bcd_muxed(i_bcd_muxed),
      .sel(r_sel),
      .dat(r_dat),
      .settled(settled),
      .changed(changed)
   );
   always_comb begin
      one_hot   = r_sel != '0 && (r_sel & (r_sel - DISPLAYS_NUM'(1))) == '0;
      full      = &mask;
`ifdef BCD_DEMUX_BCD_CHECK_EN
      bad       = r_dat > BCD_MAX;
`else
      bad       = 1'b0;
`endif
      cap       = state == S_WAIT && settled;
      wr        = cap && one_hot && !bad;
      mask_base = full ? '0 : mask;
   end
   assign o_digit_mask = mask;
   // The capture is committed on the WAIT->CAPTURE edge so the error pulses line up with CAPTURE
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= S_WAIT;
         shadow        <= '0;
         mask          <= '0;
         o_bcd_data    <= '0;
         o_frame_valid <= 1'b0;
         o_sel_err     <= 1'b0;
         o_bcd_err     <= 1'b0;
      end else begin
         state         <= state == S_WAIT ? (settled ? S_CAPTURE : S_WAIT) : (changed ? S_WAIT : S_HOLD);
         o_frame_valid <= full;
         o_sel_err     <= cap && r_sel != '0 && !one_hot;
         o_bcd_err     <= cap && one_hot && bad;
         if (full) o_bcd_data <= shadow;
         mask          <= cap && one_hot ? (bad ? '0 : mask_base | r_sel) : mask_base;
         for (int k = 0; k < DISPLAYS_NUM; k++)
            if (wr && r_sel[k]) shadow[BCD_W*(DISPLAYS_NUM-k-1) +: BCD_W] <= r_dat;
      end
   end
endmodule

// File: tb/tb_bcd_demux.sv
// tb_bcd_demux: directed scenarios with a frame scoreboard for bcd_demux
module tb_bcd_demux;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [3:0]  i_bcd_muxed = '0;
   logic [3:0]  i_bcd_sel = '0;
   logic [15:0] o_bcd_data;
   logic        o_frame_valid;
   logic [3:0]  o_digit_mask;
   logic        o_sel_err;
   logic        o_bcd_err;
   int checks = 0;
   int failures = 0;
   int frames = 0;
   int sel_errs = 0;
   int bcd_errs = 0;
   logic [15:0] exp_q[$];

   bcd_demux #(.DISPLAYS_NUM(4), .SETTLE_CYCLES(2)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_bcd_muxed(i_bcd_muxed),
      .i_bcd_sel(i_bcd_sel),
      .o_bcd_data(o_bcd_data),
      .o_frame_valid(o_frame_valid),
      .o_digit_mask(o_digit_mask),
      .o_sel_err(o_sel_err),
      .o_bcd_err(o_bcd_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] sel, input logic [3:0] dat, input int n);
      i_bcd_sel = sel;
      i_bcd_muxed = dat;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_sel_err) sel_errs++;
         if (o_bcd_err) bcd_errs++;
         if (o_frame_valid) begin
            frames++;
            if (exp_q.size() == 0) check("unexpected_frame", {16'h0, o_bcd_data}, 32'hffff_ffff);
            else check("frame_data", {16'h0, o_bcd_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_data", {16'h0, o_bcd_data}, 32'h0);
      check("reset_valid", {31'h0, o_frame_valid}, 32'h0);
      check("reset_mask", {28'h0, o_digit_mask}, 32'h0);
      check("reset_sel_err", {31'h0, o_sel_err}, 32'h0);
      check("reset_bcd_err", {31'h0, o_bcd_err}, 32'h0);
      i_rst = 1'b0;
      step(4'h0, 4'h0, 6);
      // nominal frame with cycle-exact completion timing
      exp_q.push_back(16'h1234);
      step(4'b0001, 4'h1, 10);
      check("nom_mask0", {28'h0, o_digit_mask}, 32'b0001);
      step(4'b0010, 4'h2, 10);
      check("nom_mask1", {28'h0, o_digit_mask}, 32'b0011);
      step(4'b0100, 4'h3, 10);
      check("nom_mask2", {28'h0, o_digit_mask}, 32'b0111);
      step(4'b1000, 4'h4, 3);
      check("nom_pre_capture", {28'h0, o_digit_mask}, 32'b0111);
      step(4'b1000, 4'h4, 1);
      check("nom_mask3", {28'h0, o_digit_mask}, 32'b1111);
      check("nom_valid_early", {31'h0, o_frame_valid}, 32'h0);
      step(4'b1000, 4'h4, 1);
      check("nom_valid", {31'h0, o_frame_valid}, 32'h1);
      check("nom_data", {16'h0, o_bcd_data}, 32'h1234);
      check("nom_mask_clr", {28'h0, o_digit_mask}, 32'b0000);
      step(4'b1000, 4'h4, 1);
      check("nom_valid_drop", {31'h0, o_frame_valid}, 32'h0);
      step(4'b1000, 4'h4, 7);
      check("nom_frames", frames, 1);
      // glitch rejection
      for (int i = 0; i < 8; i++) step(4'b0001, (i % 2) ? 4'h7 : 4'h5, 1);
      check("glitch_no_capture", {28'h0, o_digit_mask}, 32'b0000);
      exp_q.push_back(16'h7000);
      step(4'b0001, 4'h7, 10);
      check("glitch_capture", {28'h0, o_digit_mask}, 32'b0001);
      step(4'b0010, 4'h0, 10);
      step(4'b0100, 4'h0, 10);
      step(4'b1000, 4'h0, 10);
      check("glitch_frames", frames, 2);
      // select faults with a digit already captured
      step(4'b0001, 4'h5, 10);
      step(4'b0110, 4'h3, 10);
      check("sel_err_count", sel_errs, 1);
      check("sel_err_mask", {28'h0, o_digit_mask}, 32'b0001);
      step(4'b0000, 4'h3, 10);
      check("blank_no_err", sel_errs, 1);
      check("blank_mask", {28'h0, o_digit_mask}, 32'b0001);
      // async reset mid-frame
      step(4'b0010, 4'h2, 10);
      check("pre_reset_mask", {28'h0, o_digit_mask}, 32'b0011);
      #3 i_rst = 1'b1;
      #1;
      check("mid_reset_data", {16'h0, o_bcd_data}, 32'h0);
      check("mid_reset_mask", {28'h0, o_digit_mask}, 32'h0);
      check("mid_reset_valid", {31'h0, o_frame_valid}, 32'h0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      exp_q.push_back(16'h9876);
      step(4'b0001, 4'h9, 10);
      step(4'b0010, 4'h8, 10);
      step(4'b0100, 4'h7, 10);
      check("post_reset_partial", {28'h0, o_digit_mask}, 32'b0111);
      step(4'b1000, 4'h6, 10);
      check("post_reset_frames", frames, 3);
      // out-of-order positions with overwrite of digit 0
      exp_q.push_back(16'h3658);
      step(4'b0100, 4'h5, 10);
      step(4'b0001, 4'h1, 10);
      step(4'b0001, 4'h3, 10);
      check("ooo_mask", {28'h0, o_digit_mask}, 32'b0101);
      step(4'b1000, 4'h8, 10);
      step(4'b0010, 4'h6, 10);
      check("ooo_frames", frames, 4);
      check("ooo_mask_clr", {28'h0, o_digit_mask}, 32'b0000);
      // illegal nibble handling
      step(4'b0001, 4'h1, 10);
      step(4'b0010, 4'hC, 10);
`ifdef BCD_DEMUX_BCD_CHECK_EN
      check("bcd_err_count", bcd_errs, 1);
      check("bcd_err_mask", {28'h0, o_digit_mask}, 32'b0000);
      exp_q.push_back(16'h2468);
      step(4'b0001, 4'h2, 10);
      step(4'b0010, 4'h4, 10);
      step(4'b0100, 4'h6, 10);
      check("bcd_err_no_frame", frames, 4);
      step(4'b1000, 4'h8, 10);
`else
      check("bcd_err_tied", bcd_errs, 0);
      check("bcd_c_mask", {28'h0, o_digit_mask}, 32'b0011);
      exp_q.push_back(16'h1C50);
      step(4'b0100, 4'h5, 10);
      step(4'b1000, 4'h0, 10);
`endif
      check("final_frames", frames, 5);
      check("sel_err_total", sel_errs, 1);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
